// File: rtl/temp_monitor.sv
// rtl/temp_monitor.sv - periodic temperature poller with timeout and hysteretic alarm
//
// Polls an I2C temperature reader every POLL_CYCLES+1 clocks, waits up to
// TIMEOUT_CYCLES for the sample, publishes it and keeps an over-temperature
// alarm with T_HIGH/T_LOW hysteresis.
// Optional feature: define TEMP_AVG_EN to publish a 4-sample running average.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   monitor_en   in   polling enable (level)
//   TEMP_RD_en   out  one-cycle read request to the sensor reader
//   TEMP_DATA    in   raw signed 12-bit temperature (0.0625 C/LSB)
//   TEMP_DATA_en in   one-cycle strobe qualifying TEMP_DATA
//   temp_value   out  published signed temperature
//   temp_valid   out  one-cycle strobe on each temp_value update
//   over_temp    out  hysteretic over-temperature alarm
//   temp_fault   out  set when the sensor failed to answer in time
module temp_monitor #(
  parameter int                POLL_CYCLES    = 100_000_000,
  parameter int                TIMEOUT_CYCLES = 100_000,
  parameter logic signed [11:0] T_HIGH        = 12'h500,
  parameter logic signed [11:0] T_LOW         = 12'h4B0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        monitor_en,
  output logic        TEMP_RD_en,
  input  logic [11:0] TEMP_DATA,
  input  logic        TEMP_DATA_en,
  output logic [11:0] temp_value,
  output logic        temp_valid,
  output logic        over_temp,
  output logic        temp_fault
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] to_cnt;
  logic          accept;

  // Only a strobe seen while BUSY is a real answer; stray strobes are dropped.
  assign accept = (state == ST_BUSY) && TEMP_DATA_en;

`ifdef TEMP_AVG_EN
  logic [11:0]        hist [4];
  logic               hist_full;
  logic               avg_pend;
  logic signed [13:0] avg_sum;

  always_comb begin
    avg_sum = 14'(signed'(hist[0])) + 14'(signed'(hist[1]))
            + 14'(signed'(hist[2])) + 14'(signed'(hist[3]));
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_WAIT;
      poll_cnt   <= '0;
      to_cnt     <= '0;
      TEMP_RD_en <= 1'b0;
      temp_value <= 12'h000;
      temp_valid <= 1'b0;
      over_temp  <= 1'b0;
      temp_fault <= 1'b0;
`ifdef TEMP_AVG_EN
      for (int i = 0; i < 4; i++) hist[i] <= 12'h000;
      hist_full  <= 1'b0;
      avg_pend   <= 1'b0;
`endif
    end else begin
      TEMP_RD_en <= 1'b0;
      temp_valid <= 1'b0;

      case (state)
        ST_WAIT: begin
          if (monitor_en) begin
            if (poll_cnt == POLL_LAST) begin
              poll_cnt <= '0;
              state    <= ST_REQ;
            end else begin
              poll_cnt <= poll_cnt + PW'(1);
            end
          end else begin
            poll_cnt <= '0;
          end
        end
        ST_REQ: begin
          TEMP_RD_en <= 1'b1;
          to_cnt     <= '0;
          state      <= ST_BUSY;
        end
        ST_BUSY: begin
          to_cnt <= to_cnt + TW'(1);
          // Checked first so a strobe on the timeout cycle still counts.
          if (TEMP_DATA_en) begin
            temp_fault <= 1'b0;
            state      <= ST_WAIT;
          end else if (to_cnt == TO_LAST) begin
            temp_fault <= 1'b1;
            state      <= ST_WAIT;
          end
        end
        default: state <= ST_WAIT;
      endcase

`ifdef TEMP_AVG_EN
      if (accept) begin
        if (!hist_full) begin
          // Preload so the first published average equals the first sample.
          for (int i = 0; i < 4; i++) hist[i] <= TEMP_DATA;
          hist_full <= 1'b1;
        end else begin
          hist[3] <= hist[2];
          hist[2] <= hist[1];
          hist[1] <= hist[0];
          hist[0] <= TEMP_DATA;
        end
      end
      avg_pend <= accept;
      if (avg_pend) begin
        temp_value <= 12'(avg_sum >>> 2);
        temp_valid <= 1'b1;
      end
`else
      if (accept) begin
        temp_value <= TEMP_DATA;
        temp_valid <= 1'b1;
      end
`endif

      // Alarm follows the freshly published value one cycle later.
      if (temp_valid) begin
        if ($signed(temp_value) >= T_HIGH)
          over_temp <= 1'b1;
        else if ($signed(temp_value) <= T_LOW)
          over_temp <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_temp_monitor.sv
// tb/tb_temp_monitor.sv - scoreboard bench for temp_monitor
module tb_temp_monitor;
  localparam int P  = 10;
  localparam int TO = 20;
`ifdef TEMP_AVG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        monitor_en;
  logic        TEMP_RD_en;
  logic [11:0] TEMP_DATA;
  logic        TEMP_DATA_en;
  logic [11:0] temp_value;
  logic        temp_valid;
  logic        over_temp;
  logic        temp_fault;

  temp_monitor #(.POLL_CYCLES(P), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .monitor_en(monitor_en), .TEMP_RD_en(TEMP_RD_en),
    .TEMP_DATA(TEMP_DATA), .TEMP_DATA_en(TEMP_DATA_en), .temp_value(temp_value),
    .temp_valid(temp_valid), .over_temp(over_temp), .temp_fault(temp_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [11:0] val; logic ot; } exp_t;
  typedef struct { bit timeout; int d; logic [11:0] data; logic [11:0] val; logic ot; bit drop; } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int passed = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_rd(output int at);
    at = -1;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (TEMP_RD_en) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("rd_seen", 0, 1);
  endtask

  // Monitor: every temp_valid must match the next queued expectation,
  // and over_temp must reflect it on the following cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (temp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("temp_value", temp_value, e.val);
          @(negedge clk);
          check("over_temp", over_temp, e.ot);
        end
      end
    end
  end

  initial begin
    int r;
    int wait_entry;
    int seen_rd;
    logic [11:0] last_val;
    logic        last_ot;

`ifdef TEMP_AVG_EN
    vecs[0] = '{0, 0,  12'hFF0, 12'hFF0, 1'b0, 0};
    vecs[1] = '{0, 3,  12'h010, 12'hFF8, 1'b0, 0};
    vecs[2] = '{0, 5,  12'h010, 12'h000, 1'b0, 0};
    vecs[3] = '{0, 1,  12'h010, 12'h008, 1'b0, 0};
    vecs[4] = '{1, 0,  12'h000, 12'h000, 1'b0, 0};
    vecs[5] = '{0, 2,  12'h500, 12'h14C, 1'b0, 0};
    vecs[6] = '{0, 19, 12'h500, 12'h288, 1'b0, 0};
    vecs[7] = '{0, 2,  12'h500, 12'h3C4, 1'b0, 1};
    vecs[8] = '{1, 0,  12'h000, 12'h000, 1'b0, 0};
`else
    vecs[0] = '{0, 0,  12'h190, 12'h190, 1'b0, 0};
    vecs[1] = '{0, 3,  12'h500, 12'h500, 1'b1, 0};
    vecs[2] = '{0, 5,  12'h4C0, 12'h4C0, 1'b1, 0};
    vecs[3] = '{0, 1,  12'h4B0, 12'h4B0, 1'b0, 0};
    vecs[4] = '{1, 0,  12'h000, 12'h000, 1'b0, 0};
    vecs[5] = '{0, 2,  12'h190, 12'h190, 1'b0, 0};
    vecs[6] = '{0, 19, 12'h500, 12'h500, 1'b1, 0};
    vecs[7] = '{0, 2,  12'h4C0, 12'h4C0, 1'b1, 1};
    vecs[8] = '{1, 0,  12'h000, 12'h000, 1'b0, 0};
`endif

    rst = 1'b1; monitor_en = 1'b0; TEMP_DATA_en = 1'b0; TEMP_DATA = 12'h000;
    repeat (3) @(negedge clk);
    check("rst_rd_en", TEMP_RD_en, 0);
    check("rst_value", temp_value, 12'h000);
    check("rst_valid", temp_valid, 0);
    check("rst_over_temp", over_temp, 0);
    check("rst_fault", temp_fault, 0);

    rst = 1'b0; monitor_en = 1'b1;
    wait_entry = cyc; last_val = 12'h000; last_ot = 1'b0;

    for (int i = 0; i < 9; i++) begin
      wait_rd(r);
      check("rd_spacing", r - wait_entry, P + 1);
      if (vecs[i].drop) monitor_en = 1'b0;
      if (vecs[i].timeout) begin
        for (int k = 1; k <= TO; k++) begin
          @(posedge clk);
          @(negedge clk);
          if (k == 1) check("rd_pulse_width", TEMP_RD_en, 0);
          if (k == TO - 1) check("fault_before_timeout", temp_fault, 0);
        end
        wait_entry = cyc;
        check("timeout_fault", temp_fault, 1);
        check("timeout_value_held", temp_value, last_val);
        check("timeout_no_valid", temp_valid, 0);
        @(negedge clk);
        check("timeout_over_temp_held", over_temp, last_ot);
      end else begin
        for (int k = 0; k <= vecs[i].d; k++) begin
          if (k == vecs[i].d) begin
            sb.push_back('{vecs[i].val, vecs[i].ot});
            TEMP_DATA = vecs[i].data;
            TEMP_DATA_en = 1'b1;
          end
          @(posedge clk);
          @(negedge clk);
          if (k == 0) check("rd_pulse_width", TEMP_RD_en, 0);
          if (k == vecs[i].d) TEMP_DATA_en = 1'b0;
        end
        wait_entry = cyc;
        repeat (LAT - 1) @(negedge clk);
        check("valid_latency", temp_valid, 1);
        check("fault_after_sample", temp_fault, 0);
        last_val = vecs[i].val;
        last_ot  = vecs[i].ot;
        // A strobe while idle must be ignored.
        @(negedge clk);
        TEMP_DATA = 12'h7FF; TEMP_DATA_en = 1'b1;
        @(negedge clk);
        TEMP_DATA_en = 1'b0;
        @(negedge clk);
        check("stray_strobe_ignored", temp_value, last_val);
        if (vecs[i].drop) begin
          seen_rd = 0;
          repeat (30) begin
            @(negedge clk);
            if (TEMP_RD_en) seen_rd++;
          end
          check("no_rd_when_disabled", seen_rd, 0);
          monitor_en = 1'b1;
          wait_entry = cyc;
        end
      end
    end

    // Reset in the middle of a transaction, then a late strobe.
    wait_rd(r);
    check("rd_spacing", r - wait_entry, P + 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_value", temp_value, 12'h000);
    check("mid_rst_valid", temp_valid, 0);
    check("mid_rst_over_temp", over_temp, 0);
    check("mid_rst_fault", temp_fault, 0);
    check("mid_rst_rd_en", TEMP_RD_en, 0);
    rst = 1'b0;
    TEMP_DATA = 12'h321; TEMP_DATA_en = 1'b1;
    wait_entry = cyc;
    @(negedge clk);
    TEMP_DATA_en = 1'b0;
    wait_rd(r);
    check("rd_after_reset", r - wait_entry, P + 1);
    check("late_strobe_ignored", temp_value, 12'h000);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
